seg7_display_ctrl: RTL and testbench
====================================

Name: seg7_display_ctrl

Overview:
- Registered multi-digit hexadecimal seven-segment display controller for the DE10 HEX displays.
- Captures a packed value on a load strobe and decodes every nibble to a glyph, including lowercase b and d.
- Adds leading-zero blanking, per-digit blink driven by an internal prescaler, decimal points, lamp test and a blank-until-first-load state.
- Sits between user datapath logic and the board's HEX pins.

Parameters:
- NUM_DIGITS, 6: number of digits; legal range 1..8.
- BLINK_DIV, 25000000: clock cycles per blink half-period; must be ≥2. At 50 MHz the default gives 1 Hz blink.
- ACTIVE_LOW, 1: 1 means a lit segment is driven 0, which matches the DE10 HEX pins. 0 means a lit segment is driven 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- load  in  1  single-cycle strobe; capture value, dp_in, blink_en
- value  in  4*NUM_DIGITS  packed nibbles; digit 0 = value[3:0] = least significant
- dp_in  in  NUM_DIGITS  decimal point request per digit
- blink_en  in  NUM_DIGITS  per-digit blink enable
- blank_lz  in  1  leading-zero blanking enable; level-sensitive, not captured
- lamp_test  in  1  force every segment and dp lit; level-sensitive
- seg_out  out  7*NUM_DIGITS  digit i at [7i+6:7i], bit order g..a (bit 0 = a)
- dp_out  out  NUM_DIGITS  decimal point per digit, same polarity as seg_out
- shown  out  1  high once a load has been displayed

Behaviour:
- Reset (async): capture regs 0, valid=0, prescaler 0, phase 0, all seg_out/dp_out unlit (all ones when ACTIVE_LOW=1), shown=0.
- Pipeline has two registered stages.
  - Stage 1: load at edge N captures value/dp_in/blink_en and sets valid.
  - Stage 2: the output register updates at edge N+1. Load-to-pin latency is 2 edges.
  - Output is continuously recomputed from stage-1 contents every cycle.
- shown rises at edge N+1 after the first load. It stays high until rst.
- A load with no intervening cycles overwrites the earlier one; only the last capture is displayed. Loads are never refused.
- Glyphs, active-low, g..a order:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - When ACTIVE_LOW=0, outputs are bitwise inverted.
- Prescaler counts 0..BLINK_DIV-1 every cycle, independent of load. On the wrap cycle it returns to 0 and phase toggles.
- Per-digit output, evaluated in priority order:
  1. lamp_test=1: all 7 segments and dp lit.
  2. valid=0: digit unlit.
  3. blink_en[i]=1 and phase=1: segments and dp unlit.
  4. Digit is a leading zero: segments unlit, dp follows dp_in[i].
  5. Otherwise: glyph(nibble i), dp follows dp_in[i].
- Leading-zero rule: digit i is a leading zero when blank_lz=1, the nibble is 0, all more-significant nibbles are 0, and i≠0. Digit 0 is never LZ-blanked, so value 0 displays a single "0".
- lamp_test and blank_lz changes appear on pins one edge later.
- lamp_test does not disturb the capture regs or prescaler; on release, normal display resumes on the next edge.
- rst asserted mid-operation clears everything immediately, without waiting for a clock edge. The display stays blank until the next load.

Decomposition:
- Package seg7_pkg:
  - 16-entry active-low glyph constant array
  - SEG_BLANK (7'b1111111) and SEG_ALL (7'b0000000)
  - function apply_polarity(glyph, active_low)
- Sub-module hex_glyph_lut: combinational, 4-bit nibble in, 7-bit active-low glyph out. Instantiated NUM_DIGITS times via generate.
- Prescaler, leading-zero chain and output mux stay in seg7_display_ctrl.

Test Plan:
- Reset then idle 10 cycles -> seg_out all ones and shown=0. Load value=24'h0123AF at edge N -> at edge N+1, digits 5..0 = 1000000,1111001,0100100,0110000,0001000,0001110, and shown=1.
- blank_lz=1, load 24'h000050 -> digits 5..2 blank (1111111), digit1=0010010, digit0=1000000. Load 24'h0 -> only digit0 shows 1000000.
- BLINK_DIV=4, blink_en=6'b000001, load 24'h000008 -> digit0 alternates 0000000 / 1111111 every 4 cycles while other digits are unaffected. A load mid-period does not reset the blink phase.
- lamp_test=1 while digit blinking and LZ-blanked -> one edge later all seg_out=0 and dp_out=0. Release -> prior display restored next edge.
- dp_in=6'b000100 with blank_lz=1 and load 24'h000007 -> dp_out[2]=0 while digit2 segments are blank.
- Async rst asserted between edges after a load -> outputs blank immediately without a clock edge. Release, no load -> display stays blank. Load twice on back-to-back cycles -> only the second value ever appears on the pins.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment controller: the hex glyph table
// (active-low, g..a order) and the polarity helper.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ALL   = 7'b0000000;

  localparam logic [6:0] GLYPH_ROM [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Glyphs are stored active-low; invert for boards with active-high segments.
  function automatic logic [6:0] apply_polarity(input logic [6:0] glyph,
                                                input logic       active_low);
    return active_low ? glyph : ~glyph;
  endfunction

endpackage

// File: rtl/seg7_display_ctrl_if.sv
// Bundle between the user datapath (master) and the display controller (slave).
interface seg7_display_ctrl_if #(
  parameter int NUM_DIGITS = 6
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blink_en;
  logic                    blank_lz;
  logic                    lamp_test;
  logic [7*NUM_DIGITS-1:0] seg_out;
  logic [NUM_DIGITS-1:0]   dp_out;
  logic                    shown;

  modport master (
    output load, value, dp_in, blink_en, blank_lz, lamp_test,
    input  seg_out, dp_out, shown
  );

  modport slave (
    input  load, value, dp_in, blink_en, blank_lz, lamp_test,
    output seg_out, dp_out, shown
  );
endinterface

// File: rtl/seg7_display_ctrl_hex_glyph_lut.sv
// Combinational nibble-to-glyph decode; output is always active-low.
module hex_glyph_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = GLYPH_ROM[nibble];

endmodule

// File: rtl/seg7_display_ctrl.sv
// Registered multi-digit hex seven-segment controller: capture stage, blink
// prescaler, leading-zero blanking and a registered output stage.
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic               clk,
  input logic               rst,
  seg7_display_ctrl_if.slave bus
);

  localparam int                    CNT_W     = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(BLINK_DIV - 1);
  localparam logic [6:0]            SEG_UNLIT = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;
  localparam logic [7*NUM_DIGITS-1:0] SEG_RESET = {NUM_DIGITS{SEG_UNLIT}};
  localparam logic [NUM_DIGITS-1:0] DP_RESET  = {NUM_DIGITS{ACTIVE_LOW}};

  logic [4*NUM_DIGITS-1:0] value_reg;
  logic [NUM_DIGITS-1:0]   dp_reg;
  logic [NUM_DIGITS-1:0]   blink_reg;
  logic                    valid_reg;

  logic [CNT_W-1:0]        cnt_reg;
  logic                    phase_reg;

  logic [7*NUM_DIGITS-1:0] seg_reg;
  logic [7*NUM_DIGITS-1:0] seg_next;
  logic [NUM_DIGITS-1:0]   dp_out_reg;
  logic [NUM_DIGITS-1:0]   dp_next;
  logic                    shown_reg;

  // zero_hi[k]: nibbles k..NUM_DIGITS-1 are all zero
  logic [NUM_DIGITS:1]     zero_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_reg <= '0;
      dp_reg    <= '0;
      blink_reg <= '0;
      valid_reg <= 1'b0;
    end else if (bus.load) begin
      value_reg <= bus.value;
      dp_reg    <= bus.dp_in;
      blink_reg <= bus.blink_en;
      valid_reg <= 1'b1;
    end
  end

  // Free-running blink timebase; loads never restart it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      phase_reg <= 1'b0;
    end else if (cnt_reg == CNT_MAX) begin
      cnt_reg   <= '0;
      phase_reg <= ~phase_reg;
    end else begin
      cnt_reg   <= cnt_reg + 1'b1;
    end
  end

  assign zero_hi[NUM_DIGITS] = 1'b1;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [3:0] nibble;
    logic [6:0] glyph;
    logic [6:0] lit;
    logic       blink_off;
    logic       lz;
    logic       dp_lit;

    assign nibble = value_reg[4*gi +: 4];

    hex_glyph_lut u_lut (
      .nibble (nibble),
      .glyph  (glyph)
    );

    if (gi == 0) begin : g_lsd
      assign lz = 1'b0;
    end else begin : g_upper
      if (gi < NUM_DIGITS - 1) begin : g_chain
        assign zero_hi[gi] = (nibble == 4'h0) && zero_hi[gi+1];
      end else begin : g_top
        assign zero_hi[gi] = (nibble == 4'h0);
      end
      assign lz = bus.blank_lz && zero_hi[gi];
    end

    assign blink_off = blink_reg[gi] & phase_reg;

    // Priority: lamp test, not-yet-loaded, blink-off, leading zero, glyph.
    assign lit = bus.lamp_test                      ? SEG_ALL   :
                 (!valid_reg || blink_off || lz)    ? SEG_BLANK : glyph;
    assign dp_lit = bus.lamp_test | (valid_reg & ~blink_off & dp_reg[gi]);

    assign seg_next[7*gi +: 7] = apply_polarity(lit, ACTIVE_LOW);
    assign dp_next[gi]         = ACTIVE_LOW ? ~dp_lit : dp_lit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_reg    <= SEG_RESET;
      dp_out_reg <= DP_RESET;
      shown_reg  <= 1'b0;
    end else begin
      seg_reg    <= seg_next;
      dp_out_reg <= dp_next;
      shown_reg  <= shown_reg | valid_reg;
    end
  end

  assign bus.seg_out = seg_reg;
  assign bus.dp_out  = dp_out_reg;
  assign bus.shown   = shown_reg;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a behavioural model of the display rules.
module tb_seg7_display_ctrl;

  localparam int ND = 6;
  localparam int BD = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seg7_display_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seg7_display_ctrl #(
    .NUM_DIGITS (ND),
    .BLINK_DIV  (BD),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [6:0] gl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] m_val;
  logic [5:0]  m_dp;
  logic [5:0]  m_blink;
  logic        m_valid;
  logic        m_shown;
  int          edges;
  logic [41:0] exp_seg;
  logic [5:0]  exp_dp;
  logic        exp_shown;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_val = '0; m_dp = '0; m_blink = '0; m_valid = 1'b0; m_shown = 1'b0;
    edges = 0;
    exp_seg = '1; exp_dp = '1; exp_shown = 1'b0;
  endtask

  // Evaluate what the pins should show after this edge, then apply the capture.
  task automatic model_edge();
    int phase;
    logic [23:0] upper;
    logic [6:0]  seg;
    logic        dp_lit;
    phase = (edges / BD) % 2;
    edges++;
    for (int i = 0; i < ND; i++) begin
      upper = m_val >> (4 * i);
      if (bus.lamp_test) begin
        seg = 7'b0000000; dp_lit = 1'b1;
      end else if (!m_valid) begin
        seg = 7'b1111111; dp_lit = 1'b0;
      end else if (m_blink[i] && phase == 1) begin
        seg = 7'b1111111; dp_lit = 1'b0;
      end else begin
        if (bus.blank_lz && i != 0 && upper == 24'h0) seg = 7'b1111111;
        else seg = gl[upper[3:0]];
        dp_lit = m_dp[i];
      end
      exp_seg[7*i +: 7] = seg;
      exp_dp[i] = ~dp_lit;
    end
    m_shown = m_shown | m_valid;
    exp_shown = m_shown;
    if (bus.load) begin
      m_val = bus.value; m_dp = bus.dp_in; m_blink = bus.blink_en; m_valid = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("seg", 64'(bus.seg_out), 64'(exp_seg));
    check("dp", 64'(bus.dp_out), 64'(exp_dp));
    check("shown", 64'(bus.shown), 64'(exp_shown));
  endtask

  task automatic do_load(input logic [23:0] v, input logic [5:0] dp, input logic [5:0] bl);
    bus.load = 1'b1; bus.value = v; bus.dp_in = dp; bus.blink_en = bl;
    tick();
    bus.load = 1'b0;
  endtask

  // Called just after a tick, while clk is high: no edge occurs during reset.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_seg", 64'(bus.seg_out), 64'(42'h3FF_FFFF_FFFF));
    check("arst_dp", 64'(bus.dp_out), 64'(6'h3F));
    check("arst_shown", 64'(bus.shown), 64'd0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.blink_en = '0;
    bus.blank_lz = 1'b0; bus.lamp_test = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_seg", 64'(bus.seg_out), 64'(42'h3FF_FFFF_FFFF));
    check("rst_shown", 64'(bus.shown), 64'd0);
    for (int k = 0; k < 10; k++) tick();

    do_load(24'h0123AF, 6'h00, 6'h00);
    tick();
    check("hex_0123AF", 64'(bus.seg_out),
          64'({7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0001000, 7'b0001110}));
    check("shown_first", 64'(bus.shown), 64'd1);

    bus.blank_lz = 1'b1;
    do_load(24'h000050, 6'h00, 6'h00);
    tick();
    check("lz_50", 64'(bus.seg_out),
          64'({7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}));
    do_load(24'h000000, 6'h00, 6'h00);
    tick();
    check("lz_zero", 64'(bus.seg_out),
          64'({7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}));

    do_load(24'h000008, 6'h00, 6'h01);
    for (int k = 0; k < 10; k++) tick();
    do_load(24'h000008, 6'h00, 6'h01);
    for (int k = 0; k < 10; k++) tick();

    bus.lamp_test = 1'b1;
    tick();
    check("lamp_seg", 64'(bus.seg_out), 64'd0);
    check("lamp_dp", 64'(bus.dp_out), 64'd0);
    bus.lamp_test = 1'b0;
    tick();

    do_load(24'h000007, 6'b000100, 6'h00);
    tick();
    check("dp2_lit", 64'(bus.dp_out[2]), 64'd0);
    check("dp2_seg_blank", 64'(bus.seg_out[20:14]), 64'(7'b1111111));

    async_reset();
    for (int k = 0; k < 5; k++) tick();
    do_load(24'hAAAAAA, 6'h00, 6'h00);
    do_load(24'h00BEEF, 6'h00, 6'h00);
    for (int k = 0; k < 3; k++) tick();
    check("b2b_last", 64'(bus.seg_out[13:0]), 64'({7'b0000110, 7'b0001110}));

    for (int k = 0; k < 400; k++) begin
      bus.load      = ($urandom_range(0, 3) == 0);
      bus.value     = 24'($urandom >> $urandom_range(8, 32));
      bus.dp_in     = 6'($urandom);
      bus.blink_en  = 6'($urandom);
      bus.blank_lz  = 1'($urandom_range(0, 1));
      bus.lamp_test = ($urandom_range(0, 9) == 0);
      tick();
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
